// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, Cnd evaluation and the M pipeline register.
// Optional macro EXC_CC_GUARD_EN blocks CC writes while a downstream stage reports HLT/ADR/INS.
module execute_stage #(
    parameter int W     = 64,
    parameter int STATW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [STATW-1:0] E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [W-1:0]     E_valA,
    input  logic [W-1:0]     E_valB,
    input  logic [W-1:0]     E_valC,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic             M_bubble,
    input  logic [STATW-1:0] m_stat,
    input  logic [STATW-1:0] W_stat,
    output logic [W-1:0]     e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_Cnd,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic [STATW-1:0] M_stat,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [W-1:0]     M_valE,
    output logic [W-1:0]     M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [STATW-1:0] S_AOK = STATW'(1);

    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [3:0]   aluFun;
    logic [W-1:0] aluResult;
    logic         aluOf;
    logic         funValid;
    logic         ccGuardOk;
    logic         setCc;
    logic         cnd;

    logic zf_q, sf_q, of_q;

    logic [STATW-1:0] mStat_q;
    logic [3:0]       mIcode_q;
    logic             mCnd_q;
    logic [W-1:0]     mValE_q;
    logic [W-1:0]     mValA_q;
    logic [3:0]       mDstE_q;
    logic [3:0]       mDstM_q;

    always_comb begin
        aluA = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:              aluA = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: aluA = E_valC;
            I_CALL, I_PUSHQ:              aluA = {{(W-4){1'b1}}, 4'b1000};
            I_RET, I_POPQ:                aluA = W'(8);
            default:                      aluA = '0;
        endcase
    end

    always_comb begin
        aluB = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: aluB = E_valB;
            default: aluB = '0;
        endcase
    end

    assign aluFun   = (E_icode == I_OPQ) ? E_ifun : 4'h0;
    assign funValid = (aluFun <= 4'h3);

    // Out-of-range function codes fall to the default arm and yield zero.
    always_comb begin
        aluResult = '0;
        aluOf     = 1'b0;
        case (aluFun)
            4'h0: begin
                aluResult = aluB + aluA;
                aluOf     = (aluA[W-1] == aluB[W-1]) && (aluResult[W-1] != aluB[W-1]);
            end
            4'h1: begin
                aluResult = aluB - aluA;
                aluOf     = (aluB[W-1] != aluA[W-1]) && (aluResult[W-1] != aluB[W-1]);
            end
            4'h2:    aluResult = aluB & aluA;
            4'h3:    aluResult = aluB ^ aluA;
            default: aluResult = '0;
        endcase
    end

`ifdef EXC_CC_GUARD_EN
    function automatic logic isException(input logic [STATW-1:0] stat);
        return (stat == STATW'(2)) || (stat == STATW'(3)) || (stat == STATW'(4));
    endfunction

    assign ccGuardOk = !isException(m_stat) && !isException(W_stat);
`else
    logic unusedDownstreamStat;
    assign unusedDownstreamStat = ^{m_stat, W_stat};
    assign ccGuardOk = 1'b1;
`endif

    assign setCc = (E_icode == I_OPQ) && funValid && ccGuardOk;

    // Reset takes priority, so a reset cycle never commits the OPQ sitting in E.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (setCc) begin
            zf_q <= (aluResult == '0);
            sf_q <= aluResult[W-1];
            of_q <= aluOf;
        end
    end

    // Cnd uses the registered CC only; a freshly computed CC is visible next cycle.
    always_comb begin
        cnd = 1'b0;
        if (E_icode == I_RRMOVQ || E_icode == I_JXX) begin
            case (E_ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf_q ^ of_q) | zf_q;
                4'h2:    cnd = sf_q ^ of_q;
                4'h3:    cnd = zf_q;
                4'h4:    cnd = !zf_q;
                4'h5:    cnd = !(sf_q ^ of_q);
                4'h6:    cnd = !(sf_q ^ of_q) && !zf_q;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign e_valE = aluResult;
    assign e_Cnd  = cnd;
    assign e_dstE = (E_icode == I_RRMOVQ && !cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            mStat_q  <= S_AOK;
            mIcode_q <= I_NOP;
            mCnd_q   <= 1'b0;
            mValE_q  <= '0;
            mValA_q  <= '0;
            mDstE_q  <= RNONE;
            mDstM_q  <= RNONE;
        end else begin
            mStat_q  <= E_stat;
            mIcode_q <= E_icode;
            mCnd_q   <= cnd;
            mValE_q  <= aluResult;
            mValA_q  <= E_valA;
            mDstE_q  <= e_dstE;
            mDstM_q  <= E_dstM;
        end
    end

    assign ZF      = zf_q;
    assign SF      = sf_q;
    assign OF      = of_q;
    assign M_stat  = mStat_q;
    assign M_icode = mIcode_q;
    assign M_Cnd   = mCnd_q;
    assign M_valE  = mValE_q;
    assign M_valA  = mValA_q;
    assign M_dstE  = mDstE_q;
    assign M_dstM  = mDstM_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipelined execute stage, one step downstream of the decode register and upstream of memory.
- Selects the ALU operands, computes valE using the bitwise and arithmetic ALU units, and holds the condition-code register (ZF/SF/OF).
- Evaluates Cnd for jXX/cmovXX and registers the results into the M pipeline register.
- Drives the forwarding outputs e_valE and e_dstE.

Parameters:
- W, 64, datapath width.
- STATW, 4, status code width (AOK=1, HLT=2, ADR=3, INS=4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- E_stat  in  STATW  status from the E register.
- E_icode  in  4  instruction code.
- E_ifun  in  4  function code.
- E_valA, E_valB, E_valC  in  W  operands.
- E_dstE, E_dstM  in  4  destination registers (0xF = RNONE).
- M_bubble  in  1  load a bubble into the M register this edge.
- m_stat, W_stat  in  STATW  downstream status, used only by the optional feature.
- e_valE  out  W  combinational ALU result (forwarding).
- e_dstE  out  4  combinational destination after cmov squash (forwarding).
- e_Cnd  out  1  combinational condition result.
- ZF, SF, OF  out  1 each  condition-code register.
- M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  out  registered M-stage fields.

Behaviour:
- Icodes: HALT 0, NOP 1, CMOVXX/RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
- aluA:
  - valA for icode 2 and 6.
  - valC for icode 3, 4, 5.
  - -8 for icode 8 and A.
  - +8 for icode 9 and B.
  - 0 otherwise.
- aluB:
  - valB for icode 4, 5, 6, 8, 9, A, B.
  - 0 otherwise.
- alufun = ifun when icode = OPQ, else ADD.
  - 0 ADD: B+A.
  - 1 SUB: B-A.
  - 2 AND: B&A.
  - 3 XOR: B^A.
  - OPQ with ifun > 3: valE = 0 and CC is not written.
- Arithmetic wraps modulo 2^W.
- OF:
  - ADD: sign(A) = sign(B) and sign(result) differs from them.
  - SUB: sign(B) differs from sign(A) and sign(result) differs from sign(B).
  - AND/XOR: OF = 0.
- set_cc = (icode = OPQ) and valid ifun and not rst.
  - CC is written at the clock edge.
  - e_Cnd always reads the pre-edge CC value.
  - An OPQ immediately followed by a jXX therefore sees the new CC on the next cycle, with no bypass.
- Cnd by ifun (evaluated only for icode 2 and 7; 0 for all other icodes):
  - 0 always 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - ifun > 6 gives 0.
- e_dstE = 0xF when icode = 2 and Cnd = 0; otherwise E_dstE.
- M register, latency 1 cycle: normally loads {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
- M_bubble = 1 loads the bubble {AOK, NOP, 0, 0, 0, 0xF, 0xF}. CC update is independent of M_bubble.
- Reset (sync):
  - M register loads the bubble.
  - ZF = 1, SF = 0, OF = 0.
  - rst overrides M_bubble and set_cc in the same cycle.
  - Reset mid-stream discards the instruction currently in E.
- No stall input: the E-stage instruction always advances.

Optional Feature:
- Macro EXC_CC_GUARD_EN.
- Defined: set_cc additionally requires m_stat and W_stat both outside {HLT, ADR, INS}. This keeps an instruction younger than a faulting one from corrupting CC.
- Undefined: m_stat and W_stat are ignored, and CC updates on every valid OPQ.

Test Plan:
- Reset: rst = 1 for 1 cycle -> M_icode = 1, M_dstE = 0xF, M_stat = 1, ZF = 1, SF = 0, OF = 0.
- ADD overflow: OPQ ifun 0, valA = 1, valB = 0x7FFF_FFFF_FFFF_FFFF -> e_valE = 0x8000_0000_0000_0000; after the edge SF = 1, OF = 1, ZF = 0; M_valE matches.
- SUB equal then cmov:
  - OPQ ifun 1, valA = valB = 5 -> ZF = 1.
  - Next cycle cmovle (2/1), dstE = 3 -> e_Cnd = 1, e_dstE = 3.
  - Then cmovne (2/4) -> e_dstE = 0xF, M_Cnd = 0.
- Stack ops with CC unchanged:
  - PUSHQ with valB = 0x100 -> e_valE = 0xF8.
  - POPQ with valB = 0xF8 -> e_valE = 0x100.
  - CC unchanged across both.
- Bubble: M_bubble = 1 with OPQ ADD in E -> M fields equal the bubble values, CC still updates.
- Guard (EXC_CC_GUARD_EN defined): OPQ SUB with valA = valB = 5 while m_stat = 3 -> CC unchanged. The same stimulus with the macro undefined sets ZF = 1.
